// File: rtl/exp_align_stage_pkg.sv
// Shared widths and constants for the FP add/sub alignment stage.
package exp_align_stage_pkg;

  localparam int unsigned GrsW = 3;

  function automatic int unsigned exp_width(input int unsigned w);
    return (w == 64) ? 11 : 8;
  endfunction

  function automatic int unsigned frac_width(input int unsigned w);
    return (w == 64) ? 52 : 23;
  endfunction

  // {hidden, frac, G, R, S}
  function automatic int unsigned ext_sig_width(input int unsigned sw);
    return sw + 1 + GrsW;
  endfunction

endpackage

// File: rtl/shift_sticky_right.sv
// Combinational right shifter that folds every shifted-out bit into bit 0 as sticky.
module shift_sticky_right #(
  parameter int unsigned Width  = 27,
  parameter int unsigned ShiftW = 8
) (
  input  logic [Width-1:0]  data,
  input  logic [ShiftW-1:0] shamt,
  output logic [Width-1:0]  result
);

  logic [Width-1:0] lost_mask;
  logic             sticky;

  always_comb begin
    lost_mask = '0;
    sticky    = 1'b0;
    result    = '0;
    if (32'(shamt) >= Width) begin
      result = {{(Width-1){1'b0}}, |data};
    end else begin
      lost_mask = ~({Width{1'b1}} << shamt);
      sticky    = |(data & lost_mask);
      result    = (data >> shamt) | {{(Width-1){1'b0}}, sticky};
    end
  end

endmodule

// File: rtl/exp_align_stage.sv
// Two-register alignment stage: exponent difference and hidden bits in S1,
// sticky-preserving right shift of the smaller significand in S2.
module exp_align_stage
  import exp_align_stage_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned EW = exp_width(W),
  parameter int unsigned SW = frac_width(W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [W-2:0]      DMP_i,
  input  logic [W-2:0]      DmP_i,
  input  logic              real_op_i,
  input  logic              sgn_i,
  input  logic              zero_flag_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [EW-1:0]     exp_o,
  output logic [SW+GrsW:0]  man_max_o,
  output logic [SW+GrsW:0]  man_min_o,
  output logic              real_op_o,
  output logic              sgn_o,
  output logic              zero_flag_o
);

  localparam int unsigned SigW = ext_sig_width(SW);

  logic s1_adv, s2_adv, s1_load, s2_load;
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;

  // Stage-1 combinational front end
  logic [EW-1:0]   max_exp, min_exp, max_eff, min_eff, exp_diff;
  logic            max_hid, min_hid;
  logic [SigW-1:0] max_sig, min_sig;

  assign max_exp  = DMP_i[W-2:SW];
  assign min_exp  = DmP_i[W-2:SW];
  assign max_hid  = |max_exp;
  assign min_hid  = |min_exp;
  // Denormals behave as exponent 1 with no hidden bit.
  assign max_eff  = max_hid ? max_exp : EW'(1);
  assign min_eff  = min_hid ? min_exp : EW'(1);
  assign exp_diff = (max_eff >= min_eff) ? (max_eff - min_eff) : '0;
  assign max_sig  = {max_hid, DMP_i[SW-1:0], {GrsW{1'b0}}};
  assign min_sig  = {min_hid, DmP_i[SW-1:0], {GrsW{1'b0}}};

  logic [EW-1:0]   s1_exp_q, s1_diff_q;
  logic [SigW-1:0] s1_max_q, s1_min_q;
  logic            s1_real_op_q, s1_sgn_q, s1_zero_q;

  logic [SigW-1:0] min_aligned;

  logic [EW-1:0]   s2_exp_q;
  logic [SigW-1:0] s2_max_q, s2_min_q;
  logic            s2_real_op_q, s2_sgn_q, s2_zero_q;

  // Handshake
  assign s2_adv  = ~s2_valid_q | ready_i;
  assign s1_adv  = ~s1_valid_q | s2_adv;
  assign ready_o = s1_adv;
  assign s1_load = s1_adv & valid_i;
  assign s2_load = s2_adv & s1_valid_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (s1_adv) s1_valid_d = valid_i;
    if (s2_adv) s2_valid_d = s1_valid_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_exp_q     <= '0;
      s1_diff_q    <= '0;
      s1_max_q     <= '0;
      s1_min_q     <= '0;
      s1_real_op_q <= 1'b0;
      s1_sgn_q     <= 1'b0;
      s1_zero_q    <= 1'b0;
    end else if (s1_load) begin
      s1_exp_q     <= max_exp;
      s1_diff_q    <= exp_diff;
      s1_max_q     <= max_sig;
      s1_min_q     <= min_sig;
      s1_real_op_q <= real_op_i;
      s1_sgn_q     <= sgn_i;
      s1_zero_q    <= zero_flag_i;
    end
  end

  shift_sticky_right #(
    .Width  (SigW),
    .ShiftW (EW)
  ) u_shift (
    .data   (s1_min_q),
    .shamt  (s1_diff_q),
    .result (min_aligned)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_exp_q     <= '0;
      s2_max_q     <= '0;
      s2_min_q     <= '0;
      s2_real_op_q <= 1'b0;
      s2_sgn_q     <= 1'b0;
      s2_zero_q    <= 1'b0;
    end else if (s2_load) begin
      s2_exp_q     <= s1_exp_q;
      s2_max_q     <= s1_max_q;
      s2_min_q     <= min_aligned;
      s2_real_op_q <= s1_real_op_q;
      s2_sgn_q     <= s1_sgn_q;
      s2_zero_q    <= s1_zero_q;
    end
  end

  assign valid_o     = s2_valid_q;
  assign exp_o       = s2_exp_q;
  assign man_max_o   = s2_max_q;
  assign man_min_o   = s2_min_q;
  assign real_op_o   = s2_real_op_q;
  assign sgn_o       = s2_sgn_q;
  assign zero_flag_o = s2_zero_q;

endmodule

// File: tb/tb_exp_align_stage.sv
// Randomized scoreboard bench for exp_align_stage (W=32) plus directed corner cases.
module tb_exp_align_stage;

  logic        clk, rst;
  logic        valid_i, ready_o, ready_i, valid_o;
  logic [30:0] DMP_i, DmP_i;
  logic        real_op_i, sgn_i, zero_flag_i;
  logic [7:0]  exp_o;
  logic [26:0] man_max_o, man_min_o;
  logic        real_op_o, sgn_o, zero_flag_o;

  exp_align_stage dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .DMP_i       (DMP_i),
    .DmP_i       (DmP_i),
    .real_op_i   (real_op_i),
    .sgn_i       (sgn_i),
    .zero_flag_i (zero_flag_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .exp_o       (exp_o),
    .man_max_o   (man_max_o),
    .man_min_o   (man_min_o),
    .real_op_o   (real_op_o),
    .sgn_o       (sgn_o),
    .zero_flag_o (zero_flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  ex;
    logic [26:0] mx;
    logic [26:0] mn;
    logic        ro;
    logic        sg;
    logic        zf;
  } out_t;

  out_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: IEEE significands as integers, alignment as integer divide with remainder.
  function automatic out_t model(input logic [30:0] a, input logic [30:0] b,
                                 input logic ro, input logic sg, input logic zf);
    out_t            o;
    int unsigned     ea, eb, effa, effb, d;
    longint unsigned sa, sm, r;
    ea   = 32'(a[30:23]);
    eb   = 32'(b[30:23]);
    effa = (ea == 0) ? 1 : ea;
    effb = (eb == 0) ? 1 : eb;
    d    = (effa >= effb) ? effa - effb : 0;
    sa   = (((ea != 0) ? 64'h80_0000 : 64'd0) + 64'(a[22:0])) * 8;
    sm   = (((eb != 0) ? 64'h80_0000 : 64'd0) + 64'(b[22:0])) * 8;
    if (d >= 27) begin
      r = (sm != 0) ? 64'd1 : 64'd0;
    end else begin
      r = sm / (64'd1 << d);
      if ((sm % (64'd1 << d)) != 0) r = r | 64'd1;
    end
    o.ex = a[30:23];
    o.mx = 27'(sa);
    o.mn = 27'(r);
    o.ro = ro;
    o.sg = sg;
    o.zf = zf;
    return o;
  endfunction

  task automatic check_out(input string tag, input out_t w);
    check({tag, "_exp"}, 32'(exp_o), 32'(w.ex));
    check({tag, "_max"}, 32'(man_max_o), 32'(w.mx));
    check({tag, "_min"}, 32'(man_min_o), 32'(w.mn));
    check({tag, "_flags"}, 32'({real_op_o, sgn_o, zero_flag_o}), 32'({w.ro, w.sg, w.zf}));
  endtask

  // One cycle: drive at negedge, observe 1 ns later, score emit then accept.
  task automatic step(input logic v, input logic [30:0] a, input logic [30:0] b,
                      input logic ro, input logic sg, input logic zf, input logic rdy);
    out_t e;
    @(negedge clk);
    valid_i = v; DMP_i = a; DmP_i = b;
    real_op_i = ro; sgn_i = sg; zero_flag_i = zf; ready_i = rdy;
    #1;
    if (valid_o && ready_i) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 32'(valid_o), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_out("sb", e);
      end
    end
    if (valid_i && ready_o) sb_q.push_back(model(a, b, ro, sg, zf));
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 31'd0, 31'd0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  function automatic logic [30:0] rnd_op(input logic [7:0] e);
    logic [22:0] f;
    f = 23'($urandom);
    if ($urandom_range(0, 15) == 0) f = '0;
    return {e, f};
  endfunction

  initial begin
    logic [30:0] p0, p1, p2, a, b, t;
    logic [7:0]  ea, eb;
    int unsigned dd;

    rst = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    DMP_i = '0; DmP_i = '0; real_op_i = 1'b0; sgn_i = 1'b0; zero_flag_i = 1'b0;
    #12;
    check("rst_valid", 32'(valid_o), 32'd0);
    check_out("rst", '0);
    @(negedge clk); rst = 1'b1;
    #1 check("rst_ready", 32'(ready_o), 32'd1);

    // Exponent difference 1, latency exactly 2
    step(1'b1, 31'h4000_0000, 31'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("lat_not_early", 32'(valid_o), 32'd0);
    idle(1'b1);
    check("lat_valid", 32'(valid_o), 32'd1);
    check("t1_exp", 32'(exp_o), 32'h80);
    check("t1_max", 32'(man_max_o), 32'h400_0000);
    check("t1_min", 32'(man_min_o), 32'h200_0000);

    // Shift beyond width: only sticky survives
    step(1'b1, 31'h4E80_0000, 31'h3F80_0001, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b1); idle(1'b1);
    check("t2_exp", 32'(exp_o), 32'h9D);
    check("t2_max", 32'(man_max_o), 32'h400_0000);
    check("t2_min", 32'(man_min_o), 32'h1);

    // Denormal smaller operand, d = 0
    step(1'b1, 31'h0080_0000, 31'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1); idle(1'b1);
    check("t3_exp", 32'(exp_o), 32'h01);
    check("t3_max", 32'(man_max_o), 32'h400_0000);
    check("t3_min", 32'(man_min_o), 32'h8);

    // Both zero: flags pass through, significands zero
    step(1'b1, 31'd0, 31'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b1); idle(1'b1);
    check("t4_valid", 32'(valid_o), 32'd1);
    check_out("t4", '{ex: 8'h00, mx: 27'd0, mn: 27'd0, ro: 1'b1, sg: 1'b0, zf: 1'b1});
    idle(1'b1); idle(1'b1);

    // Back-to-back streaming at full rate
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 31'h4000_0000 + 31'(i), 31'h3F00_0000 + 31'(i << 4), 1'b0, 1'(i), 1'b0, 1'b1);
      check("tput_ready", 32'(ready_o), 32'd1);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("tput_drain", 32'(sb_q.size()), 32'd0);

    // Backpressure: two accepts then stall, outputs held
    p0 = 31'h4100_1234; p1 = 31'h4200_0FFF; p2 = 31'h3FFF_FFFF;
    step(1'b1, p0, 31'h3E00_0007, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_acc0", 32'(ready_o), 32'd1);
    step(1'b1, p1, 31'h4080_0001, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bp_acc1", 32'(ready_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, p2, 31'h3F00_0003, 1'b0, 1'b1, 1'b0, 1'b0);
      check("bp_stall_ready", 32'(ready_o), 32'd0);
      check("bp_stall_valid", 32'(valid_o), 32'd1);
      check_out("bp_hold", model(p0, 31'h3E00_0007, 1'b0, 1'b0, 1'b0));
    end
    step(1'b1, p2, 31'h3F00_0003, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("bp_drain", 32'(sb_q.size()), 32'd0);

    // Reset with both stages full
    step(1'b1, p1, 31'h3F00_0003, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, p0, 31'h3F00_0003, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    check("mid_full", 32'(valid_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_valid", 32'(valid_o), 32'd0);
    check_out("mid_rst", '0);
    sb_q.delete();
    @(negedge clk); rst = 1'b1;
    #1 check("mid_ready", 32'(ready_o), 32'd1);
    step(1'b1, 31'h4000_0000, 31'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("mid_lat_early", 32'(valid_o), 32'd0);
    idle(1'b1);
    check("mid_lat_valid", 32'(valid_o), 32'd1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 2000; i++) begin
      ea = 8'($urandom_range(0, 254));
      dd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 27);
      eb = (32'(ea) > dd) ? 8'(32'(ea) - dd) : 8'd0;
      a  = rnd_op(ea);
      b  = rnd_op(eb);
      if ($urandom_range(0, 15) == 0) begin
        t = a; a = b; b = t;
      end
      step(1'($urandom_range(0, 9) < 7), a, b, 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 5; i++) idle(1'b1);
    check("rand_drain", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exp_align_stage.md
Name: exp_align_stage

Overview:
- Pipelined alignment stage directly downstream of the operand-ordering stage of the FP add/subtract unit.
- Takes the ordered magnitudes (larger DMP, smaller DmP) plus the real-operation, sign and zero flags from that stage.
- Computes the exponent difference, restores hidden bits and right-shifts the smaller significand with guard/round/sticky.
- Hands the aligned significands to the significand adder under a valid/ready handshake.

Parameters:
W, 32, total IEEE 754 width (32 single, 64 double)
EW, 8, exponent width (8 for W=32, 11 for W=64)
SW, 23, fraction width (23 for W=32, 52 for W=64)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
valid_i  input  1  upstream holds a valid operand pair
ready_o  output  1  stage can accept a new pair this cycle
DMP_i  input  W-1  larger magnitude {exp, frac}
DmP_i  input  W-1  smaller magnitude {exp, frac}
real_op_i  input  1  effective operation (1 = subtract)
sgn_i  input  1  final result sign
zero_flag_i  input  1  result is exactly zero
valid_o  output  1  outputs hold a valid aligned pair
ready_i  input  1  downstream accepts this cycle
exp_o  output  EW  exponent field of DMP (raw)
man_max_o  output  SW+4  {hidden, frac, 3'b000}
man_min_o  output  SW+4  {hidden, frac, G, R, S} after alignment
real_op_o, sgn_o, zero_flag_o  output  1 each  registered copies of the inputs

Behaviour:
- Reset (rst low, async): both stage valid bits cleared. All outputs are 0. ready_o is 1 after reset release.
- Transfer occurs when valid && ready on a side. The pipeline has 2 register stages, so latency is 2 cycles from input accept to valid_o. Throughput is 1 pair per cycle.
- Stage 1 (S1) registers:
  - hidden bit = (exp field != 0);
  - effective exponent = max(exp field, 1), so denormals use exponent 1;
  - d = eff_exp(DMP) - eff_exp(DmP), EW bits, unsigned. Never negative by contract; if the input violates the contract, d is clamped to 0.
  - exp_o source, flags, and both extended significands {hidden, frac, 000}.
- Stage 2 (S2) registers:
  - man_max unchanged.
  - man_min shifted right by d. S = OR of all bits shifted out, ORed into bit 0.
  - If d >= SW+4: man_min = {0..0, S}, where S = OR of the whole pre-shift significand.
- Handshake and stall:
  - S2 advances when !s2_valid || ready_i.
  - S1 advances when !s1_valid || S2 advances.
  - ready_o = that S1 advance condition. It is combinational from ready_i; no other combinational input-to-output path exists.
  - Held data is stable while valid_o=1 and ready_i=0.
  - Simultaneous accept and emit in the same cycle loses no data.
- Zero operands: hidden=0, frac=0 yields an all-zero significand. zero_flag passes through unchanged and does not force outputs.
- Reset asserted mid-operation drops in-flight data. valid_o falls asynchronously.

Decomposition:
- Shared package holds:
  - EW/SW values per W;
  - the GRS width constant (3);
  - the extended significand width SW+4.
- One sub-module: shift_sticky_right, a combinational barrel right shifter (parameter SW+4) with sticky OR-reduction. It is instantiated in S2.
- The handshake and pipeline registers stay in exp_align_stage.

Test Plan:
- W=32, DMP=0x40000000, DmP=0x3F800000, ready_i=1.
  → 2 cycles later: valid_o=1, exp_o=0x80, man_max_o=0x4000000, man_min_o=0x2000000.
- DMP=0x4E800000, DmP=0x3F800001 (d=30 ≥ 27).
  → exp_o=0x9D, man_max_o=0x4000000, man_min_o=0x0000001 (sticky only).
- Denormal: DMP=0x00800000, DmP=0x00000001 (d=0).
  → man_max_o=0x4000000, man_min_o=0x0000008, exp_o=0x01.
- Backpressure: stream 3 pairs with ready_i=0.
  → after 2 accepts ready_o=0, and outputs are held stable.
  - Then raise ready_i. → All 3 pairs emerge in order, no loss or duplication.
- Reset mid-flight: pulse rst low with both stages valid.
  → valid_o=0 and all outputs 0 immediately. ready_o=1 after release. The next accepted pair appears 2 cycles later.
- Both zero with real_op_i=1, zero_flag_i=1.
  → man_max_o=man_min_o=0, exp_o=0, zero_flag_o=1, real_op_o=1.
